// File: rtl/mcu_cmd_receiver_if.sv
// Signal bundle between the MCU command receiver and the flows it triggers.
// master: the receiver (consumes TXD_MCU, drives requests); slave: the request consumer.
interface mcu_cmd_receiver_if;
  logic        TXD_MCU;
  logic        baud_req;
  logic [7:0]  baud_cmd;
  logic        demand_addr_req;
  logic        erase_req;
  logic        bad_block_req;
  logic [11:0] bad_block_addr;
  logic        frame_err;
  logic        rx_busy;

  modport master (
    input  TXD_MCU,
    output baud_req, baud_cmd, demand_addr_req, erase_req,
           bad_block_req, bad_block_addr, frame_err, rx_busy
  );

  modport slave (
    output TXD_MCU,
    input  baud_req, baud_cmd, demand_addr_req, erase_req,
           bad_block_req, bad_block_addr, frame_err, rx_busy
  );
endinterface

// File: rtl/mcu_cmd_receiver.sv
// 8N1 UART command receiver: assembles C0/C2/CE/C3 frames into single-cycle requests.
// Optional fifth XOR checksum byte per frame when CMD_RX_CHECKSUM_EN is defined.
module mcu_cmd_receiver #(
  parameter int CLKS_PER_BIT = 24,
  parameter int TIMEOUT_CLKS = 4800
) (
  input  logic               clk,
  input  logic               rst_n,
  mcu_cmd_receiver_if.master bus
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CNT_W-1:0] HALF_BIT  = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CLKS);

  localparam logic [7:0] HDR_BAUD   = 8'hC0;
  localparam logic [7:0] HDR_DEMAND = 8'hC2;
  localparam logic [7:0] HDR_BAD    = 8'hC3;
  localparam logic [7:0] HDR_ERASE  = 8'hCE;

  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_state_t;
  typedef enum logic [2:0] {
    F_HDR, F_SUB, F_DLO, F_DHI
`ifdef CMD_RX_CHECKSUM_EN
    , F_CHK
`endif
  } frm_state_t;

  logic sync1_q, sync2_q, rx_prev_q;

  bit_state_t       bit_q, bit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             stop_sample, byte_valid, stop_err;

  frm_state_t       frm_q, frm_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tmo_hit, hdr_ok, fire;
  logic [7:0]       hdr_q, hdr_d, dlo_q, dlo_d;
  logic [3:0]       dhi_nib;
`ifdef CMD_RX_CHECKSUM_EN
  logic [7:0]       dhi_q, dhi_d;
`endif
  logic             baud_req_q, baud_req_d, demand_q, demand_d;
  logic             erase_q, erase_d, bad_q, bad_d, err_q, err_d;
  logic [7:0]       baud_cmd_q, baud_cmd_d;
  logic [11:0]      bba_q, bba_d;

  // rx_prev_q lets IDLE see a genuine high-to-low edge rather than a held-low line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= bus.TXD_MCU;
      sync2_q   <= sync1_q;
      rx_prev_q <= sync2_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_q   <= B_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    case (bit_q)
      B_IDLE: begin
        if (rx_prev_q && !sync2_q) begin
          bit_d = B_START;
          cnt_d = '0;
        end
      end
      B_START: begin
        if (cnt_q == HALF_BIT) begin
          cnt_d = '0;
          idx_d = '0;
          bit_d = sync2_q ? B_IDLE : B_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      B_DATA: begin
        if (cnt_q == LAST_BIT) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) bit_d = B_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (cnt_q == LAST_BIT) begin
          cnt_d = '0;
          bit_d = B_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    stop_sample = (bit_q == B_STOP) && (cnt_q == LAST_BIT);
    byte_valid  = stop_sample && sync2_q;
    stop_err    = stop_sample && !sync2_q;
  end

  assign hdr_ok  = (shift_q == HDR_BAUD) || (shift_q == HDR_DEMAND) ||
                   (shift_q == HDR_BAD)  || (shift_q == HDR_ERASE);
  assign tmo_hit = (frm_q != F_HDR) && (tmo_q == TMO_LIMIT);

  // The counter saturates at the limit; the frame FSM drops to HDR the next cycle, clearing it.
  always_comb begin
    tmo_d = tmo_q;
    if (byte_valid || frm_q == F_HDR) tmo_d = '0;
    else if (bit_q == B_IDLE && !tmo_hit) tmo_d = tmo_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frm_q <= F_HDR;
    else        frm_q <= frm_d;
  end

  always_comb begin
    frm_d = frm_q;
    if (stop_err || tmo_hit) begin
      frm_d = F_HDR;
    end else if (byte_valid) begin
      case (frm_q)
        F_HDR: frm_d = hdr_ok ? F_SUB : F_HDR;
        F_SUB: frm_d = (shift_q == 8'h00) ? F_DLO : F_HDR;
        F_DLO: frm_d = F_DHI;
`ifdef CMD_RX_CHECKSUM_EN
        F_DHI: frm_d = F_CHK;
`endif
        default: frm_d = F_HDR;
      endcase
    end
  end

  always_comb begin
    baud_req_d = 1'b0;
    demand_d   = 1'b0;
    erase_d    = 1'b0;
    bad_d      = 1'b0;
    err_d      = stop_err || tmo_hit;
    fire       = 1'b0;
    baud_cmd_d = baud_cmd_q;
    bba_d      = bba_q;
    hdr_d      = hdr_q;
    dlo_d      = dlo_q;
`ifdef CMD_RX_CHECKSUM_EN
    dhi_d      = dhi_q;
    dhi_nib    = dhi_q[3:0];
`else
    dhi_nib    = shift_q[3:0];
`endif
    if (byte_valid) begin
      case (frm_q)
        F_HDR: begin
          if (hdr_ok) hdr_d = shift_q;
          else        err_d = 1'b1;
        end
        F_SUB: err_d = (shift_q != 8'h00);
        F_DLO: dlo_d = shift_q;
`ifdef CMD_RX_CHECKSUM_EN
        F_DHI: dhi_d = shift_q;
        F_CHK: begin
          if (shift_q == (hdr_q ^ dlo_q ^ dhi_q)) fire  = 1'b1;
          else                                    err_d = 1'b1;
        end
`else
        F_DHI: fire = 1'b1;
`endif
        default: ;
      endcase
    end
    if (fire) begin
      case (hdr_q)
        HDR_BAUD: begin
          baud_req_d = 1'b1;
          baud_cmd_d = dlo_q;
        end
        HDR_DEMAND: demand_d = 1'b1;
        HDR_ERASE:  erase_d  = 1'b1;
        default: begin
          bad_d = 1'b1;
          bba_d = {dhi_nib, dlo_q};
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q      <= '0;
      hdr_q      <= '0;
      dlo_q      <= '0;
`ifdef CMD_RX_CHECKSUM_EN
      dhi_q      <= '0;
`endif
      baud_req_q <= 1'b0;
      demand_q   <= 1'b0;
      erase_q    <= 1'b0;
      bad_q      <= 1'b0;
      err_q      <= 1'b0;
      baud_cmd_q <= '0;
      bba_q      <= '0;
    end else begin
      tmo_q      <= tmo_d;
      hdr_q      <= hdr_d;
      dlo_q      <= dlo_d;
`ifdef CMD_RX_CHECKSUM_EN
      dhi_q      <= dhi_d;
`endif
      baud_req_q <= baud_req_d;
      demand_q   <= demand_d;
      erase_q    <= erase_d;
      bad_q      <= bad_d;
      err_q      <= err_d;
      baud_cmd_q <= baud_cmd_d;
      bba_q      <= bba_d;
    end
  end

  assign bus.baud_req        = baud_req_q;
  assign bus.baud_cmd        = baud_cmd_q;
  assign bus.demand_addr_req = demand_q;
  assign bus.erase_req       = erase_q;
  assign bus.bad_block_req   = bad_q;
  assign bus.bad_block_addr  = bba_q;
  assign bus.frame_err       = err_q;
  assign bus.rx_busy         = (frm_q != F_HDR);
endmodule
